// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared sizes and state encoding for the GSIM host sequencer
package gsim_pkg;

  localparam int N     = 16;
  localparam int BW    = 16;
  localparam int XW    = 32;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    PREP    = 3'd1,
    SEND    = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DRAIN   = 3'd5
  } state_t;

endpackage

// File: rtl/gsim_vec_buf.sv
// rtl/gsim_vec_buf.sv - N-entry vector buffer, one write port and one asynchronous read port
module gsim_vec_buf #(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [W-1:0]         rdata
);

  // Contents are always written before being read, so no reset is needed.
  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gsim_host.sv
// rtl/gsim_host.sv - host sequencer: load b, reset and feed the solver, capture and drain x
module gsim_host #(
  parameter int N       = gsim_pkg::N,
  parameter int BW      = gsim_pkg::BW,
  parameter int XW      = gsim_pkg::XW,
  parameter int TIMEOUT = 2048
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [BW-1:0] s_data,
  output logic          gsim_rst,
  output logic          in_en,
  output logic [BW-1:0] b_in,
  input  logic          out_valid,
  input  logic [XW-1:0] x_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [XW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          err_timeout,
  output logic          err_short
);

  import gsim_pkg::*;

  localparam int AW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   IDX_LAST = (AW+1)'(N - 1);
  localparam logic [AW:0]   IDX_END  = (AW+1)'(N);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state, state_d;
  // One index serves as write count, send index, capture index and drain pointer.
  logic [AW:0]   idx, idx_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          gsim_rst_d, in_en_d, err_timeout_d, err_short_d;
  logic [BW-1:0] b_in_d;

  logic          b_we, x_we;
  logic [AW-1:0] b_raddr, x_waddr;
  logic [BW-1:0] b_rdata;
  logic [XW-1:0] x_rdata;

  gsim_vec_buf #(.W(BW), .N(N)) u_bbuf (
    .clk   (clk),
    .we    (b_we),
    .waddr (idx[AW-1:0]),
    .wdata (s_data),
    .raddr (b_raddr),
    .rdata (b_rdata)
  );

  gsim_vec_buf #(.W(XW), .N(N)) u_xbuf (
    .clk   (clk),
    .we    (x_we),
    .waddr (x_waddr),
    .wdata (x_out),
    .raddr (idx[AW-1:0]),
    .rdata (x_rdata)
  );

  assign s_ready = (state == LOAD);
  assign busy    = (state != LOAD);
  assign m_valid = (state == DRAIN);
  assign m_data  = m_valid ? x_rdata : '0;
  assign m_last  = m_valid && (idx == IDX_LAST);

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    tcnt_d        = tcnt;
    gsim_rst_d    = 1'b0;
    in_en_d       = 1'b0;
    b_in_d        = b_in;
    err_timeout_d = err_timeout;
    err_short_d   = err_short;
    b_we          = 1'b0;
    x_we          = 1'b0;
    b_raddr       = idx[AW-1:0];
    x_waddr       = idx[AW-1:0];

    case (state)
      LOAD: begin
        if (s_valid) begin
          b_we = 1'b1;
          if (idx == '0) begin
            err_timeout_d = 1'b0;
            err_short_d   = 1'b0;
          end
          if (idx == IDX_LAST) begin
            idx_d      = '0;
            gsim_rst_d = 1'b1;
            state_d    = PREP;
          end else begin
            idx_d = idx + (AW+1)'(1);
          end
        end
      end
      PREP: begin
        // The first b word is presented on the same edge that leaves PREP.
        b_raddr = '0;
        in_en_d = 1'b1;
        b_in_d  = b_rdata;
        idx_d   = (AW+1)'(1);
        state_d = SEND;
      end
      SEND: begin
        if (idx == IDX_END) begin
          idx_d   = '0;
          tcnt_d  = '0;
          state_d = WAIT;
        end else begin
          in_en_d = 1'b1;
          b_in_d  = b_rdata;
          idx_d   = idx + (AW+1)'(1);
        end
      end
      WAIT: begin
        if (out_valid) begin
          x_we    = 1'b1;
          x_waddr = '0;
          idx_d   = (AW+1)'(1);
          tcnt_d  = '0;
          state_d = CAPTURE;
        end else if (tcnt == TO_LAST) begin
          err_timeout_d = 1'b1;
          tcnt_d        = '0;
          idx_d         = '0;
          state_d       = LOAD;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      CAPTURE: begin
        if (out_valid) begin
          x_we = 1'b1;
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx + (AW+1)'(1);
          end
        end else begin
          err_short_d = 1'b1;
          idx_d       = '0;
          state_d     = LOAD;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx + (AW+1)'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD;
      idx         <= '0;
      tcnt        <= '0;
      gsim_rst    <= 1'b0;
      in_en       <= 1'b0;
      b_in        <= '0;
      err_timeout <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      tcnt        <= tcnt_d;
      gsim_rst    <= gsim_rst_d;
      in_en       <= in_en_d;
      b_in        <= b_in_d;
      err_timeout <= err_timeout_d;
      err_short   <= err_short_d;
    end
  end

endmodule
